rename_map_table: RTL and testbench

// Speculative front-end register alias table; the consumer of the RRAT copy bus on rollback.

---
 rtl/rename_map_table.sv | 128 ++++++++++++
 tb/tb_rename_map_table.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map_table.sv
// Speculative register alias table for a 2-wide rename stage: arch -> phys tag plus ready bit,
// CDB wakeup of ready bits, and whole-table restore from the committed map on rollback.
module rename_map_table #(
  parameter int SCALAR         = 2,
  parameter int NUM_ENTRIES    = 32,
  parameter int AREG_IDX_WIDTH = 5,
  parameter int PREG_IDX_WIDTH = 6
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [SCALAR-1:0]                     rename_en,
  input  logic [SCALAR*AREG_IDX_WIDTH-1:0]      src1_arch,
  input  logic [SCALAR*AREG_IDX_WIDTH-1:0]      src2_arch,
  input  logic [SCALAR*AREG_IDX_WIDTH-1:0]      dest_arch,
  input  logic [SCALAR*PREG_IDX_WIDTH-1:0]      new_preg,
  input  logic [SCALAR-1:0]                     cdb_valid,
  input  logic [SCALAR*PREG_IDX_WIDTH-1:0]      cdb_tag,
  input  logic                                  rollback,
  input  logic [NUM_ENTRIES*PREG_IDX_WIDTH-1:0] rrat_copy_tag,
  output logic [SCALAR*PREG_IDX_WIDTH-1:0]      src1_preg,
  output logic [SCALAR-1:0]                     src1_ready,
  output logic [SCALAR*PREG_IDX_WIDTH-1:0]      src2_preg,
  output logic [SCALAR-1:0]                     src2_ready,
  output logic [SCALAR*PREG_IDX_WIDTH-1:0]      old_dest_preg
);

  localparam int A = AREG_IDX_WIDTH;
  localparam int P = PREG_IDX_WIDTH;

  typedef logic [A-1:0] areg_t;
  typedef logic [P-1:0] preg_t;

  preg_t                  tag_q   [NUM_ENTRIES];
  preg_t                  tag_d   [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] ready_q;
  logic [NUM_ENTRIES-1:0] ready_d;

  // Per-lane views of the flat ports; source index j = 2*lane + (0: src1, 1: src2).
  areg_t src_arch [2*SCALAR];
  areg_t dst      [SCALAR];
  preg_t npreg    [SCALAR];
  preg_t ctag     [SCALAR];
  preg_t rd_preg  [2*SCALAR];
  logic  rd_ready [2*SCALAR];
  preg_t od_preg  [SCALAR];

  for (genvar k = 0; k < SCALAR; k++) begin : g_lane
    assign src_arch[2*k]         = src1_arch[k*A +: A];
    assign src_arch[2*k+1]       = src2_arch[k*A +: A];
    assign dst[k]                = dest_arch[k*A +: A];
    assign npreg[k]              = new_preg[k*P +: P];
    assign ctag[k]               = cdb_tag[k*P +: P];
    assign src1_preg[k*P +: P]   = rd_preg[2*k];
    assign src2_preg[k*P +: P]   = rd_preg[2*k+1];
    assign src1_ready[k]         = rd_ready[2*k];
    assign src2_ready[k]         = rd_ready[2*k+1];
    assign old_dest_preg[k*P +: P] = od_preg[k];
  end

  logic                   lane0_renames;
  logic [NUM_ENTRIES-1:0] cdb_hit;

  assign lane0_renames = rename_en[0] && (dst[0] != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    cdb_hit = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int k = 0; k < SCALAR; k++) begin
        if (cdb_valid[k] && (ctag[k] == tag_q[i])) cdb_hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 2*SCALAR; j++) begin
      rd_preg[j]  = '0;
      rd_ready[j] = 1'b1;
      // Lane 1 sees lane 0's fresh allocation, which can never already be complete.
      if ((j >= 2) && lane0_renames && (src_arch[j] == dst[0])) begin
        rd_preg[j]  = npreg[0];
        rd_ready[j] = 1'b0;
      end else if (src_arch[j] != '0) begin
        rd_preg[j]  = tag_q[src_arch[j]];
        rd_ready[j] = ready_q[src_arch[j]] | cdb_hit[src_arch[j]];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < SCALAR; k++) begin
      od_preg[k] = '0;
      if (dst[k] != '0) begin
        if ((k == 1) && lane0_renames && (dst[1] == dst[0])) od_preg[k] = npreg[0];
        else                                                 od_preg[k] = tag_q[dst[k]];
      end
    end
  end

  always_comb begin
    tag_d   = tag_q;
    ready_d = ready_q | cdb_hit;
    // Later lanes overwrite earlier ones, so lane 1 wins a shared destination.
    for (int k = 0; k < SCALAR; k++) begin
      if (rename_en[k] && (dst[k] != '0)) begin
        tag_d[dst[k]]   = npreg[k];
        ready_d[dst[k]] = 1'b0;
      end
    end
    if (rollback) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tag_d[i] = rrat_copy_tag[i*P +: P];
      ready_d = '1;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: the table is a flop array rather than a RAM, so it can be reset to the identity map.
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tag_q[i] <= P'(i);
      ready_q <= '1;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      tag_q   <= tag_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Self-checking bench for rename_map_table: directed scenarios plus random traffic, scored
// against a sequential rename model through an expectation queue.
module tb_rename_map_table;

  localparam int A = 5;
  localparam int P = 6;
  localparam int N = 32;

  logic           clock = 1'b0;
  logic           reset;
  logic [1:0]     rename_en;
  logic [2*A-1:0] src1_arch, src2_arch, dest_arch;
  logic [2*P-1:0] new_preg;
  logic [1:0]     cdb_valid;
  logic [2*P-1:0] cdb_tag;
  logic           rollback;
  logic [N*P-1:0] rrat_copy_tag;
  logic [2*P-1:0] src1_preg, src2_preg, old_dest_preg;
  logic [1:0]     src1_ready, src2_ready;

  always #5 clock = ~clock;

  rename_map_table dut (
    .clock         (clock),
    .reset         (reset),
    .rename_en     (rename_en),
    .src1_arch     (src1_arch),
    .src2_arch     (src2_arch),
    .dest_arch     (dest_arch),
    .new_preg      (new_preg),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .rollback      (rollback),
    .rrat_copy_tag (rrat_copy_tag),
    .src1_preg     (src1_preg),
    .src1_ready    (src1_ready),
    .src2_preg     (src2_preg),
    .src2_ready    (src2_ready),
    .old_dest_preg (old_dest_preg)
  );

  typedef struct packed {
    logic            chk;
    logic [31:0]     cyc;
    logic [1:0][5:0] s1p;
    logic [1:0][5:0] s2p;
    logic [1:0][5:0] od;
    logic [1:0]      s1r;
    logic [1:0]      s2r;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_n  = 0;

  // Reference model: committed view of the table after the last clock edge.
  int unsigned mtag [N];
  bit          mrdy [N];

  task automatic check(input string name, input int unsigned cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit cdb_hit(input int unsigned t);
    for (int k = 0; k < 2; k++)
      if (cdb_valid[k] && (int'(cdb_tag[k*P +: P]) == t)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic read_src(input int unsigned a, input int unsigned tt[N], input bit fresh[N],
                          output logic [5:0] p, output logic r);
    if (a == 0) begin
      p = '0; r = 1'b1;
    end else if (fresh[a]) begin
      p = 6'(tt[a]); r = 1'b0;
    end else begin
      p = 6'(tt[a]); r = mrdy[a] | cdb_hit(tt[a]);
    end
  endtask

  // Renames the group lane by lane in program order, queues the expected outputs, then
  // applies the clock-edge effects to the model.
  task automatic step();
    exp_t        e;
    int unsigned tt [N];
    bit          fresh [N];
    int unsigned d;
    logic [5:0]  p;
    logic        r;
    e       = '0;
    e.chk   = reset && !rollback;
    e.cyc   = cyc_n;
    tt      = mtag;
    fresh   = '{default: 1'b0};
    for (int k = 0; k < 2; k++) begin
      read_src(src1_arch[k*A +: A], tt, fresh, p, r);
      e.s1p[k] = p; e.s1r[k] = r;
      read_src(src2_arch[k*A +: A], tt, fresh, p, r);
      e.s2p[k] = p; e.s2r[k] = r;
      d = dest_arch[k*A +: A];
      e.od[k] = (d == 0) ? 6'd0 : 6'(tt[d]);
      if (rename_en[k] && d != 0) begin
        tt[d]    = new_preg[k*P +: P];
        fresh[d] = 1'b1;
      end
    end
    if (!reset) begin
      for (int i = 0; i < N; i++) begin mtag[i] = i; mrdy[i] = 1'b1; end
    end else if (rollback) begin
      for (int i = 0; i < N; i++) begin mtag[i] = rrat_copy_tag[i*P +: P]; mrdy[i] = 1'b1; end
    end else begin
      for (int i = 0; i < N; i++) if (cdb_hit(mtag[i])) mrdy[i] = 1'b1;
      for (int i = 0; i < N; i++) if (fresh[i]) begin mtag[i] = tt[i]; mrdy[i] = 1'b0; end
    end
    sb_q.push_back(e);
    cyc_n++;
  endtask

  task automatic clear_inputs();
    reset         = 1'b1;
    rename_en     = '0;
    src1_arch     = '0;
    src2_arch     = '0;
    dest_arch     = '0;
    new_preg      = '0;
    cdb_valid     = '0;
    cdb_tag       = '0;
    rollback      = 1'b0;
    rrat_copy_tag = '0;
  endtask

  task automatic set_lane(input int k, input int s1, input int s2, input int d, input int np);
    src1_arch[k*A +: A] = A'(s1);
    src2_arch[k*A +: A] = A'(s2);
    dest_arch[k*A +: A] = A'(d);
    new_preg[k*P +: P]  = P'(np);
  endtask

  function automatic int rand_areg();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 31));
  endfunction

  // Monitor: outputs are combinational, so one queued expectation per cycle is compared
  // shortly after the stimulus settles and well before the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk) begin
          for (int k = 0; k < 2; k++) begin
            check($sformatf("lane%0d src1_preg", k),     e.cyc, src1_preg[k*P +: P],     e.s1p[k]);
            check($sformatf("lane%0d src1_ready", k),    e.cyc, src1_ready[k],           e.s1r[k]);
            check($sformatf("lane%0d src2_preg", k),     e.cyc, src2_preg[k*P +: P],     e.s2p[k]);
            check($sformatf("lane%0d src2_ready", k),    e.cyc, src2_ready[k],           e.s2r[k]);
            check($sformatf("lane%0d old_dest_preg", k), e.cyc, old_dest_preg[k*P +: P], e.od[k]);
          end
        end
      end
    end
  end

  initial begin
    clear_inputs();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin mtag[i] = i; mrdy[i] = 1'b1; end

    // Reset beats a simultaneous rollback and rename.
    @(negedge clock); clear_inputs();
    reset = 1'b0; rollback = 1'b1; rename_en = 2'b11;
    set_lane(0, 1, 2, 3, 40); set_lane(1, 5, 6, 4, 41);
    for (int i = 0; i < N; i++) rrat_copy_tag[i*P +: P] = P'($urandom);
    step();

    // Identity map after reset.
    @(negedge clock); clear_inputs(); set_lane(0, 7, 9, 12, 0); set_lane(1, 0, 31, 17, 0); step();

    // Intra-group bypass, both lanes renaming x3.
    @(negedge clock); clear_inputs(); rename_en = 2'b11;
    set_lane(0, 1, 2, 3, 40); set_lane(1, 3, 0, 3, 41); step();
    @(negedge clock); clear_inputs(); set_lane(0, 3, 1, 3, 0); step();

    // CDB forwarding on a same-cycle read, then the committed wakeup.
    @(negedge clock); clear_inputs(); rename_en = 2'b01; set_lane(0, 0, 0, 5, 40); step();
    @(negedge clock); clear_inputs(); cdb_valid = 2'b10; cdb_tag[P +: P] = 6'd40;
    set_lane(0, 5, 3, 0, 0); step();
    @(negedge clock); clear_inputs(); set_lane(0, 5, 0, 0, 0); step();

    // Rename beats a same-cycle CDB hit on the new tag.
    @(negedge clock); clear_inputs(); rename_en = 2'b01; set_lane(0, 0, 0, 5, 42);
    cdb_valid = 2'b01; cdb_tag[0 +: P] = 6'd42; step();
    @(negedge clock); clear_inputs(); set_lane(0, 5, 0, 0, 0); step();

    // Rollback to rrat[i] = i+32, with a concurrent rename and CDB that must be ignored.
    @(negedge clock); clear_inputs(); rename_en = 2'b11;
    set_lane(0, 0, 0, 8, 20); set_lane(1, 0, 0, 9, 21); step();
    @(negedge clock); clear_inputs(); rollback = 1'b1; rename_en = 2'b11;
    set_lane(0, 0, 0, 10, 60); set_lane(1, 0, 0, 11, 61);
    cdb_valid = 2'b11; cdb_tag = {6'd21, 6'd20};
    for (int i = 0; i < N; i++) rrat_copy_tag[i*P +: P] = P'(i + 32);
    step();
    for (int r = 0; r < 8; r++) begin
      @(negedge clock); clear_inputs();
      set_lane(0, 4*r, 4*r + 1, 4*r + 2, 0); set_lane(1, 4*r + 2, 4*r + 3, 4*r + 3, 0);
      step();
    end

    // x0 as destination is never written; as source it is always tag 0, ready.
    @(negedge clock); clear_inputs(); rename_en = 2'b11;
    set_lane(0, 0, 0, 0, 50); set_lane(1, 0, 0, 0, 51); step();
    @(negedge clock); clear_inputs(); set_lane(0, 0, 0, 0, 0); set_lane(1, 0, 7, 0, 0); step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock); clear_inputs();
      rename_en = 2'($urandom);
      for (int k = 0; k < 2; k++)
        set_lane(k, rand_areg(), rand_areg(), rand_areg(), int'($urandom_range(0, 63)));
      cdb_valid = 2'($urandom);
      for (int k = 0; k < 2; k++)
        cdb_tag[k*P +: P] = ($urandom_range(0, 3) != 0) ? P'(mtag[$urandom_range(0, N-1)])
                                                        : P'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        rollback = 1'b1;
        for (int i = 0; i < N; i++) rrat_copy_tag[i*P +: P] = P'($urandom);
      end
      if ($urandom_range(0, 99) == 0) reset = 1'b0;
      step();
    end

    @(negedge clock); clear_inputs();
    repeat (3) @(negedge clock);
    #3;
    check("scoreboard drain", cyc_n, sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
